// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD constants and binary-to-digit split helper
package clock_pkg;

  localparam int BCD_W     = 4;
  localparam int DIGIT_MAX = 9;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_pair_t;

  function automatic bcd_pair_t split_bcd(input int value);
    bcd_pair_t r;
    r.tens = BCD_W'(value / 10);
    r.ones = BCD_W'(value % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit: load, forced wrap, up/down step, carry/borrow
module bcd_digit
  import clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_data,
  input  logic             i_wrap,
  input  logic [BCD_W-1:0] i_wrap_to,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_co
);

  localparam logic [BCD_W-1:0] MAXD = BCD_W'(DIGIT_MAX);

  logic [BCD_W-1:0] r_digit;
  logic [BCD_W-1:0] w_next;
  logic             w_at_edge;

  assign w_at_edge = i_up ? (r_digit == MAXD) : (r_digit == '0);
  assign o_co      = i_en & w_at_edge;
  assign o_digit   = r_digit;

  // Forced wrap beats a plain step so a short modulus can restart mid-digit.
  always_comb begin
    w_next = r_digit;
    if (i_load) begin
      w_next = i_load_data;
    end else if (i_wrap) begin
      w_next = i_wrap_to;
    end else if (i_en) begin
      if (i_up) begin
        w_next = w_at_edge ? '0 : r_digit + 1'b1;
      end else begin
        w_next = w_at_edge ? MAXD : r_digit - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= RST_VAL;
    end else begin
      r_digit <= w_next;
    end
  end

endmodule

// File: rtl/modn_bcd_counter.sv
// rtl/modn_bcd_counter.sv - two-digit mod-N BCD up/down counter with load and sticky load error
module modn_bcd_counter
  import clock_pkg::*;
#(
  parameter int MOD  = 60,
  parameter int INIT = 0
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic       UP,
  input  logic       LD,
  input  logic [3:0] D_Tens,
  input  logic [3:0] D_Ones,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       CO,
  output logic       ERR
);

  generate
    if (MOD < 2 || MOD > 100) begin : g_bad_mod
      $error("modn_bcd_counter: MOD must lie in 2..100");
    end
    if (INIT < 0 || INIT >= MOD) begin : g_bad_init
      $error("modn_bcd_counter: INIT must lie in 0..MOD-1");
    end
  endgenerate

  localparam bcd_pair_t        INIT_BCD = split_bcd(INIT);
  localparam bcd_pair_t        LAST_BCD = split_bcd(MOD - 1);
  localparam logic [7:0]       LAST_V   = 8'(MOD - 1);
  localparam logic [7:0]       MOD_V    = 8'(MOD);
  localparam logic [BCD_W-1:0] MAXD     = BCD_W'(DIGIT_MAX);

  logic [7:0]       w_v;
  logic [7:0]       w_d_v;
  logic             w_ld_legal;
  logic             w_load;
  logic             w_step;
  logic             w_wrap;
  logic             w_ones_co;
  logic             w_tens_en;
  logic             w_tens_co;
  logic [BCD_W-1:0] w_ones_wrap_to;
  logic [BCD_W-1:0] w_tens_wrap_to;
  logic             r_err;

  assign w_v        = 8'(Tens) * 8'd10 + 8'(Ones);
  assign w_d_v      = 8'(D_Tens) * 8'd10 + 8'(D_Ones);
  assign w_ld_legal = (D_Tens <= MAXD) && (D_Ones <= MAXD) && (w_d_v < MOD_V);
  assign w_load     = LD & w_ld_legal;
  assign w_step     = EN & ~LD;
  assign w_tens_en  = w_step & w_ones_co;

  // Counting down, both digits reporting borrow means V==0, so the tens chain gives CO directly.
  assign CO     = UP ? (w_step & (w_v == LAST_V)) : w_tens_co;
  assign w_wrap = CO;

  assign w_ones_wrap_to = UP ? '0 : LAST_BCD.ones;
  assign w_tens_wrap_to = UP ? '0 : LAST_BCD.tens;

  bcd_digit #(.RST_VAL(INIT_BCD.ones)) u_ones (
    .clk         (CP),
    .rst         (reset),
    .i_en        (w_step),
    .i_up        (UP),
    .i_load      (w_load),
    .i_load_data (D_Ones),
    .i_wrap      (w_wrap),
    .i_wrap_to   (w_ones_wrap_to),
    .o_digit     (Ones),
    .o_co        (w_ones_co)
  );

  bcd_digit #(.RST_VAL(INIT_BCD.tens)) u_tens (
    .clk         (CP),
    .rst         (reset),
    .i_en        (w_tens_en),
    .i_up        (UP),
    .i_load      (w_load),
    .i_load_data (D_Tens),
    .i_wrap      (w_wrap),
    .i_wrap_to   (w_tens_wrap_to),
    .o_digit     (Tens),
    .o_co        (w_tens_co)
  );

  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (LD && !w_ld_legal) begin
      r_err <= 1'b1;
    end
  end

  assign ERR = r_err;

endmodule

// File: tb/tb_modn_bcd_counter.sv
// tb/tb_modn_bcd_counter.sv - randomized bench for modn_bcd_counter against an integer model
module tb_modn_bcd_counter;

  logic       CP = 1'b0;
  logic       reset;
  logic       en, up, ld;
  logic [3:0] dt, d_o;

  logic [3:0] a_t, a_o, b_t, b_o, c_t, c_o;
  logic       a_co, a_err, b_co, b_err, c_co, c_err;
  logic [3:0] c1_t, c1_o, c2_t, c2_o;
  logic       c1_co, c1_err, c2_co, c2_err;

  int n_checks = 0;
  int n_fail   = 0;

  int mmod [3] = '{60, 24, 100};
  int minit[3] = '{0, 0, 30};
  int mv   [3];
  bit merr [3];
  int mc1, mc2;

  always #5 CP = ~CP;

  modn_bcd_counter #(.MOD(60), .INIT(0)) u_a (
    .CP(CP), .reset(reset), .EN(en), .UP(up), .LD(ld), .D_Tens(dt), .D_Ones(d_o),
    .Tens(a_t), .Ones(a_o), .CO(a_co), .ERR(a_err));

  modn_bcd_counter #(.MOD(24), .INIT(0)) u_b (
    .CP(CP), .reset(reset), .EN(en), .UP(up), .LD(ld), .D_Tens(dt), .D_Ones(d_o),
    .Tens(b_t), .Ones(b_o), .CO(b_co), .ERR(b_err));

  modn_bcd_counter #(.MOD(100), .INIT(30)) u_c (
    .CP(CP), .reset(reset), .EN(en), .UP(up), .LD(ld), .D_Tens(dt), .D_Ones(d_o),
    .Tens(c_t), .Ones(c_o), .CO(c_co), .ERR(c_err));

  modn_bcd_counter #(.MOD(60), .INIT(0)) u_ch1 (
    .CP(CP), .reset(reset), .EN(1'b1), .UP(1'b1), .LD(1'b0), .D_Tens(4'd0), .D_Ones(4'd0),
    .Tens(c1_t), .Ones(c1_o), .CO(c1_co), .ERR(c1_err));

  modn_bcd_counter #(.MOD(60), .INIT(0)) u_ch2 (
    .CP(CP), .reset(reset), .EN(c1_co), .UP(1'b1), .LD(1'b0), .D_Tens(4'd0), .D_Ones(4'd0),
    .Tens(c2_t), .Ones(c2_o), .CO(c2_co), .ERR(c2_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k]   = minit[k];
      merr[k] = 1'b0;
    end
    mc1 = 0;
    mc2 = 0;
  endtask

  task automatic check_state();
    chk("a_tens", 32'(a_t), 32'(mv[0] / 10));
    chk("a_ones", 32'(a_o), 32'(mv[0] % 10));
    chk("a_err",  32'(a_err), 32'(merr[0]));
    chk("b_tens", 32'(b_t), 32'(mv[1] / 10));
    chk("b_ones", 32'(b_o), 32'(mv[1] % 10));
    chk("b_err",  32'(b_err), 32'(merr[1]));
    chk("c_tens", 32'(c_t), 32'(mv[2] / 10));
    chk("c_ones", 32'(c_o), 32'(mv[2] % 10));
    chk("c_err",  32'(c_err), 32'(merr[2]));
    chk("ch1_val", 32'(c1_t) * 10 + 32'(c1_o), 32'(mc1));
    chk("ch2_val", 32'(c2_t) * 10 + 32'(c2_o), 32'(mc2));
    chk("ch_err",  32'({c1_err, c2_err}), 32'd0);
  endtask

  // Entered between edges: check state, drive, check CO, advance model, move to next negedge.
  task automatic cycle(input logic e, input logic u, input logic l,
                       input logic [3:0] t, input logic [3:0] o);
    int  dv;
    bit  co_exp [3];
    check_state();
    en = e; up = u; ld = l; dt = t; d_o = o;
    #1;
    for (int k = 0; k < 3; k++)
      co_exp[k] = e && !l && (u ? (mv[k] == mmod[k] - 1) : (mv[k] == 0));
    chk("a_co", 32'(a_co), 32'(co_exp[0]));
    chk("b_co", 32'(b_co), 32'(co_exp[1]));
    chk("c_co", 32'(c_co), 32'(co_exp[2]));
    chk("ch1_co", 32'(c1_co), 32'(mc1 == 59));
    chk("ch2_co", 32'(c2_co), 32'(mc1 == 59 && mc2 == 59));
    dv = int'(t) * 10 + int'(o);
    for (int k = 0; k < 3; k++) begin
      if (l) begin
        if (t <= 4'd9 && o <= 4'd9 && dv < mmod[k]) mv[k] = dv;
        else merr[k] = 1'b1;
      end else if (e) begin
        mv[k] = u ? (mv[k] + 1) % mmod[k] : (mv[k] + mmod[k] - 1) % mmod[k];
      end
    end
    if (mc1 == 59) mc2 = (mc2 + 1) % 60;
    mc1 = (mc1 + 1) % 60;
    @(negedge CP);
  endtask

  task automatic rand_cycle();
    logic e, l;
    logic [3:0] t, o;
    e = ($urandom_range(0, 9) < 8);
    l = ($urandom_range(0, 11) == 0);
    t = 4'($urandom_range(0, 11));
    o = 4'($urandom_range(0, 11));
    if ($urandom_range(0, 7) == 0) up = ~up;
    cycle(e, up, l, t, o);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; up = 1'b1; ld = 1'b0; dt = 4'd0; d_o = 4'd0;
    model_reset();
    repeat (2) @(posedge CP);
    @(negedge CP);
    chk("rst_a", 32'({a_t, a_o, a_err}), 32'd0);
    chk("rst_c", 32'({c_t, c_o}), 32'h30);
    chk("rst_c_err", 32'(c_err), 32'd0);
    en = 1'b1; up = 1'b0;
    #1;
    chk("rst_co_a", 32'(a_co), 32'd1);
    chk("rst_co_c", 32'(c_co), 32'd0);
    en = 1'b0; up = 1'b1;
    reset = 1'b0;
    #1;

    repeat (61) cycle(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("req32_a_wrapped", 32'({a_t, a_o}), 32'h01);

    cycle(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("req33_b_23", 32'({b_t, b_o}), 32'h23);
    cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd9);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("req33_b_18", 32'({b_t, b_o}), 32'h18);
    cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("req33_b_09", 32'({b_t, b_o}), 32'h09);

    cycle(1'b0, 1'b1, 1'b1, 4'd3, 4'd7);
    cycle(1'b1, 1'b1, 1'b1, 4'd6, 4'd5);
    chk("req34_hold", 32'({a_t, a_o}), 32'h37);
    chk("req34_err", 32'(a_err), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 4'd1, 4'd2);
    chk("req34_load12", 32'({a_t, a_o}), 32'h12);
    chk("req34_err_sticky", 32'(a_err), 32'd1);

    cycle(1'b0, 1'b1, 1'b1, 4'd5, 4'd9);
    en = 1'b1; up = 1'b1; ld = 1'b1; dt = 4'd0; d_o = 4'd5;
    #1;
    chk("req35_co", 32'(a_co), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 4'd0, 4'd5);
    chk("req35_val", 32'({a_t, a_o}), 32'h05);

    repeat (400) rand_cycle();

    reset = 1'b1;
    #1;
    chk("req36_c", 32'({c_t, c_o}), 32'h30);
    chk("req36_err", 32'({a_err, b_err, c_err}), 32'd0);
    chk("req36_a", 32'({a_t, a_o}), 32'h00);
    model_reset();
    reset = 1'b0;
    #1;

    repeat (3600) rand_cycle();
    chk("req37_chain_home", 32'({c1_t, c1_o, c2_t, c2_o}), 32'd0);
    check_state();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modn_bcd_counter.md
MODN_BCD_COUNTER -- requirements
Module: modn_bcd_counter

Interface
REQ-001 Parameter MOD, default 60: count modulus; the count sequence is 0..MOD-1; legal range 2..100.
REQ-002 Parameter INIT, default 0: reset value of the count; legal range 0..MOD-1.
REQ-003 CP  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 EN  input  1  count enable; hold when low.
REQ-006 UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 LD  input  1  synchronous parallel load request.
REQ-008 D_Tens  input  4  BCD tens digit to load.
REQ-009 D_Ones  input  4  BCD ones digit to load.
REQ-010 Tens  output  4  BCD tens digit of the count, registered.
REQ-011 Ones  output  4  BCD ones digit of the count, registered.
REQ-012 CO  output  1  cascade carry/borrow, combinational.
REQ-013 ERR  output  1  sticky illegal-load flag, registered.

Function
REQ-014 Count value V SHALL equal 10*Tens+Ones; both digits SHALL always lie in 0..9, and V SHALL always lie in 0..MOD-1.
REQ-015 Per-edge priority SHALL be: LD, then EN, then hold.
REQ-016 Load legality: load is legal if D_Tens<=9, D_Ones<=9 and 10*D_Tens+D_Ones<MOD.
REQ-017 On a legal load, the counter SHALL take D_Tens/D_Ones on the next edge, regardless of EN or UP.
REQ-018 On an illegal load, the count SHALL hold and ERR SHALL be set to 1 on that edge.
REQ-019 Count up (EN=1, LD=0, UP=1):
  - V==MOD-1 -> V becomes 0.
  - Else, Ones==9 -> Ones becomes 0 and Tens increments.
  - Else Ones increments.
REQ-020 Count down (EN=1, LD=0, UP=0):
  - V==0 -> V becomes MOD-1.
  - Else, Ones==0 -> Ones becomes 9 and Tens decrements.
  - Else Ones decrements.
REQ-021 CO SHALL be EN & ~LD & (UP ? V==MOD-1 : V==0), so it is high for exactly the cycle before a wrap.
REQ-022 CO SHALL drive the EN of a following stage directly with zero added latency.
REQ-023 A change of UP takes effect on the next enabled edge; no extra step or skip occurs.
REQ-024 ERR SHALL stay high once set; a legal load SHALL NOT clear it; only reset clears it.
REQ-025 MOD=100 SHALL give the full 00..99 range, with wrap from 99 to 00.

Reset
REQ-026 reset high SHALL immediately force Tens/Ones to the digits of INIT and ERR to 0, independent of CP.
REQ-027 While reset is high, LD and EN SHALL be ignored; CO SHALL follow REQ-021 using the reset value.
REQ-028 After reset deasserts, the first rising CP edge SHALL perform normal operation.

Structure
REQ-029 Shared package clock_pkg SHALL hold:
  - BCD digit width constant (4);
  - digit maximum constant (9);
  - a function splitting a binary value 0..99 into tens/ones digits, used for INIT and MOD-1.
REQ-030 Sub-module bcd_digit SHALL be instantiated twice, once per digit. Its ports:
  - inputs: clock, reset, enable, up, load, load data, wrap-to value;
  - outputs: digit, carry/borrow.
REQ-031 Illegal MOD or INIT SHALL cause an elaboration-time error.

Verification
REQ-032 MOD=60, reset, EN=1, UP=1 for 60 edges -> sequence 00..59 then 00; CO high only while V=59.
REQ-033 MOD=24, load 00, UP=0, EN=1 -> next edge 23; CO high at V=00; 19 -> 18; 10 -> 09.
REQ-034 MOD=60, V=37, LD=1 with D=6/5 (65) -> V stays 37, ERR=1; then legal load 12 -> V=12, ERR still 1.
REQ-035 LD=1 and EN=1 together at V=59, D=0/5 -> V=05 and CO=0 during that cycle.
REQ-036 Assert reset mid-count between edges with INIT=30 -> outputs 30 and ERR=0 immediately, without waiting for a CP edge.
REQ-037 Two instances chained (MOD=60, then MOD=60 with EN=CO of the first) -> second stage steps 59->00 exactly when the first wraps; 3600 edges return both stages to 00.
